// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the fetch port, the MEM-stage data port and the shared
//            single-port memory bus handled by mem_arbiter.
// Modports : slave  - arbiter side (takes requests, drives responses and mem_*)
//            master - environment side (CPU requesters plus memory model)
// Signals  : i_*   fetch request / response
//            d_*   data load/store request / response, loadtype/strtype funct3
//            mem_* word-addressed memory port with byte strobes
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
   // fetch port
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        i_err;
   // data port
   logic        d_rd;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  loadtype;
   logic [2:0]  strtype;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   // memory port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, loadtype, strtype,
             mem_rdata, mem_ready,
      output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, loadtype, strtype,
             mem_rdata, mem_ready,
      input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates a fetch requester and a load/store requester onto one
//            word-wide memory port. Data wins unless it has already taken
//            FAIR_MAX consecutive grants while a fetch waits. Handles byte
//            lane steering for stores, extraction/extension for loads,
//            misalignment detection and a per-access ready timeout.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_arbiter_if.slave (fetch, data and memory signals)
// Params   : TIMEOUT  (1..255) BUSY cycles without mem_ready before abort
//            FAIR_MAX max consecutive data grants while a fetch is pending
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT  = 255,
   parameter int FAIR_MAX = 2
) (
   input  wire          clk,
   input  wire          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_D = 2'd1,
      S_BUSY_I = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [7:0]          c_TIMEOUT  = 8'(TIMEOUT);
   localparam int                  c_FAIR_W   = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
   localparam logic [c_FAIR_W-1:0] c_FAIR_MAX = c_FAIR_W'(FAIR_MAX);
   localparam logic [c_FAIR_W-1:0] c_FAIR_ONE = c_FAIR_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              r_state;
   logic [c_FAIR_W-1:0] r_fair_cnt;
   logic [7:0]          r_wait_cnt;
   logic [1:0]          r_lsb;       // byte offset of the load in flight
   logic [2:0]          r_ltype;     // load funct3 of the load in flight
   logic                r_mem_req;
   logic                r_mem_we;
   logic [31:0]         r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic [3:0]          r_mem_wstrb;
   logic [31:0]         r_i_rdata;
   logic                r_i_done;
   logic                r_i_err;
   logic [31:0]         r_d_rdata;
   logic                r_d_done;
   logic                r_d_err;

   state_t              w_state;
   logic [c_FAIR_W-1:0] w_fair_cnt;
   logic [7:0]          w_wait_cnt;
   logic [1:0]          w_lsb;
   logic [2:0]          w_ltype;
   logic                w_mem_req;
   logic                w_mem_we;
   logic [31:0]         w_mem_addr;
   logic [31:0]         w_mem_wdata;
   logic [3:0]          w_mem_wstrb;
   logic [31:0]         w_i_rdata;
   logic                w_i_done;
   logic                w_i_err;
   logic [31:0]         w_d_rdata;
   logic                w_d_done;
   logic                w_d_err;

   // ------------------------------------------------------------------------
   // Request decode (live inputs, used only in IDLE)
   // ------------------------------------------------------------------------
   logic        w_d_pend;
   logic        w_d_store;
   logic        w_st_ok;
   logic [3:0]  w_st_strb;
   logic [31:0] w_st_data;
   logic        w_ld_ok;
   logic        w_d_ok;
   logic        w_i_ok;

   assign w_d_pend  = bus.d_rd | bus.d_wr;
   assign w_d_store = bus.d_wr;           // d_wr alone or with d_rd means store
   assign w_i_ok    = (bus.i_addr[1:0] == 2'b00);
   assign w_d_ok    = w_d_store ? w_st_ok : w_ld_ok;

   // Store data is replicated across lanes; the strobes pick the live lanes.
   always_comb begin
      w_st_ok   = 1'b0;
      w_st_strb = 4'b0000;
      w_st_data = 32'h0000_0000;
      case (bus.strtype)
         3'b000: begin
            w_st_ok   = 1'b1;
            w_st_strb = 4'b0001 << bus.d_addr[1:0];
            w_st_data = {4{bus.d_wdata[7:0]}};
         end
         3'b001: begin
            w_st_ok   = ~bus.d_addr[0];
            w_st_strb = 4'b0011 << bus.d_addr[1:0];
            w_st_data = {2{bus.d_wdata[15:0]}};
         end
         3'b010: begin
            w_st_ok   = (bus.d_addr[1:0] == 2'b00);
            w_st_strb = 4'b1111;
            w_st_data = bus.d_wdata;
         end
         default: ;  // undefined code: reported as misaligned
      endcase
   end

   always_comb begin
      w_ld_ok = 1'b0;
      case (bus.loadtype)
         3'b000, 3'b100: w_ld_ok = 1'b1;
         3'b001, 3'b101: w_ld_ok = ~bus.d_addr[0];
         3'b010:         w_ld_ok = (bus.d_addr[1:0] == 2'b00);
         default:        w_ld_ok = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Load result extraction from the returned word
   // ------------------------------------------------------------------------
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_data;

   assign w_ld_byte = bus.mem_rdata[{r_lsb, 3'b000} +: 8];
   assign w_ld_half = r_lsb[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

   always_comb begin
      w_ld_data = bus.mem_rdata;
      case (r_ltype)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b100:  w_ld_data = {24'h00_0000, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b101:  w_ld_data = {16'h0000, w_ld_half};
         default: w_ld_data = bus.mem_rdata;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state     = r_state;
      w_fair_cnt  = r_fair_cnt;
      w_wait_cnt  = r_wait_cnt;
      w_lsb       = r_lsb;
      w_ltype     = r_ltype;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_mem_wstrb = r_mem_wstrb;
      w_i_rdata   = r_i_rdata;
      w_i_done    = 1'b0;           // done/err only live in the RESP cycle
      w_i_err     = 1'b0;
      w_d_rdata   = r_d_rdata;
      w_d_done    = 1'b0;
      w_d_err     = 1'b0;

      // Fairness only matters while a fetch is actually waiting.
      if (!bus.i_req) begin
         w_fair_cnt = '0;
      end

      case (r_state)
         S_IDLE: begin
            if (w_d_pend && (r_fair_cnt < c_FAIR_MAX)) begin
               if (bus.i_req) begin
                  w_fair_cnt = r_fair_cnt + c_FAIR_ONE;
               end
               if (w_d_ok) begin
                  w_state     = S_BUSY_D;
                  w_mem_req   = 1'b1;
                  w_mem_we    = w_d_store;
                  w_mem_addr  = {bus.d_addr[31:2], 2'b00};
                  w_mem_wstrb = w_d_store ? w_st_strb : 4'b0000;
                  w_mem_wdata = w_d_store ? w_st_data : 32'h0000_0000;
                  w_wait_cnt  = 8'd0;
                  w_lsb       = bus.d_addr[1:0];
                  w_ltype     = bus.loadtype;
               end else begin
                  // misaligned or undefined access never reaches memory
                  w_state   = S_RESP;
                  w_d_done  = 1'b1;
                  w_d_err   = 1'b1;
                  w_d_rdata = 32'h0000_0000;
               end
            end else if (bus.i_req) begin
               w_fair_cnt = '0;
               if (w_i_ok) begin
                  w_state     = S_BUSY_I;
                  w_mem_req   = 1'b1;
                  w_mem_we    = 1'b0;
                  w_mem_addr  = {bus.i_addr[31:2], 2'b00};
                  w_mem_wstrb = 4'b0000;
                  w_mem_wdata = 32'h0000_0000;
                  w_wait_cnt  = 8'd0;
               end else begin
                  w_state   = S_RESP;
                  w_i_done  = 1'b1;
                  w_i_err   = 1'b1;
                  w_i_rdata = 32'h0000_0000;
               end
            end
         end

         S_BUSY_D, S_BUSY_I: begin
            if (bus.mem_ready) begin
               w_state     = S_RESP;
               w_mem_req   = 1'b0;
               w_mem_we    = 1'b0;
               w_mem_wstrb = 4'b0000;
               if (r_state == S_BUSY_D) begin
                  w_d_done  = 1'b1;
                  // r_mem_we still marks the access as a store here
                  w_d_rdata = r_mem_we ? 32'h0000_0000 : w_ld_data;
               end else begin
                  w_i_done  = 1'b1;
                  w_i_rdata = bus.mem_rdata;
               end
            end else if ((r_wait_cnt + 8'd1) == c_TIMEOUT) begin
               w_state     = S_RESP;
               w_wait_cnt  = r_wait_cnt + 8'd1;
               w_mem_req   = 1'b0;
               w_mem_we    = 1'b0;
               w_mem_wstrb = 4'b0000;
               if (r_state == S_BUSY_D) begin
                  w_d_done  = 1'b1;
                  w_d_err   = 1'b1;
                  w_d_rdata = 32'h0000_0000;
               end else begin
                  w_i_done  = 1'b1;
                  w_i_err   = 1'b1;
                  w_i_rdata = 32'h0000_0000;
               end
            end else begin
               w_wait_cnt = r_wait_cnt + 8'd1;
            end
         end

         S_RESP: begin
            w_state = S_IDLE;   // response cycle never grants
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_fair_cnt  <= '0;
         r_wait_cnt  <= 8'd0;
         r_lsb       <= 2'b00;
         r_ltype     <= 3'b000;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0000_0000;
         r_mem_wdata <= 32'h0000_0000;
         r_mem_wstrb <= 4'b0000;
         r_i_rdata   <= 32'h0000_0000;
         r_i_done    <= 1'b0;
         r_i_err     <= 1'b0;
         r_d_rdata   <= 32'h0000_0000;
         r_d_done    <= 1'b0;
         r_d_err     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_fair_cnt  <= w_fair_cnt;
         r_wait_cnt  <= w_wait_cnt;
         r_lsb       <= w_lsb;
         r_ltype     <= w_ltype;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_mem_wstrb <= w_mem_wstrb;
         r_i_rdata   <= w_i_rdata;
         r_i_done    <= w_i_done;
         r_i_err     <= w_i_err;
         r_d_rdata   <= w_d_rdata;
         r_d_done    <= w_d_done;
         r_d_err     <= w_d_err;
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.i_done    = r_i_done;
   assign bus.i_err     = r_i_err;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.d_done    = r_d_done;
   assign bus.d_err     = r_d_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles in BUSY waiting for mem_ready before abort; range 1..255.
REQ-002 Parameter FAIR_MAX, default 2: max consecutive data grants while i_req is pending.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 i_req  in  1  fetch request; held high until i_done.
REQ-006 i_addr  in  32  fetch byte address.
REQ-007 i_rdata  out  32  fetched word, valid with i_done.
REQ-008 i_done  out  1  one-cycle fetch completion pulse.
REQ-009 i_err  out  1  fetch error (misaligned/timeout), valid with i_done.
REQ-010 d_rd, d_wr  in  1 each  MEM-stage load/store request; held until d_done; both high = store.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data, right-aligned.
REQ-013 loadtype, strtype  in  3 each  funct3 encodings: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-014 d_rdata  out  32  extended load result, valid with d_done.
REQ-015 d_done  out  1  one-cycle data completion pulse.
REQ-016 d_err  out  1  data error, valid with d_done.
REQ-017 mem_req, mem_we  out  1 each  memory port request / write enable.
REQ-018 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-019 mem_wdata  out  32  lane-shifted store data; mem_wstrb  out  4  byte enables.
REQ-020 mem_rdata  in  32  read word; mem_ready  in  1  completes current mem_req in the same cycle.

Function
REQ-021 FSM states IDLE, BUSY_D, BUSY_I, RESP; all mem_* and response outputs registered.
REQ-022 IDLE: data pending (d_rd|d_wr) and fair count < FAIR_MAX -> BUSY_D; else i_req -> BUSY_I; else stay.
REQ-023 Fair counter: increments per data grant while i_req high, clears on any fetch grant or when i_req low.
REQ-024 On BUSY entry: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=1 only for stores, wait counter cleared.
REQ-025 mem_* outputs stable for the whole BUSY state.
REQ-026 BUSY with mem_ready=1 -> RESP; mem_req drops on the same edge.
REQ-027 Wait counter increments each BUSY cycle without mem_ready; reaching TIMEOUT -> RESP with err=1, rdata=0, mem_req dropped.
REQ-028 RESP lasts exactly one cycle: done of the served requester =1, other done =0; no grant in RESP; then IDLE.
REQ-029 Minimum latency: request seen at edge k, mem_req high after k, ready same cycle, done high after edge k+1.
REQ-030 Misaligned (half at odd address, word with addr[1:0]!=0, fetch with addr[1:0]!=0): IDLE -> RESP directly, err=1, no mem_req.
REQ-031 Store strobes: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; wdata replicated into selected lanes.
REQ-032 Load: select byte/half from mem_rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-033 Undefined loadtype/strtype codes are treated as misaligned errors.
REQ-034 i_rdata/d_rdata hold last value outside done cycles; err cleared when done=0.

Reset
REQ-035 rst=0 immediately forces IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, all done/err=0, rdata=0, counters=0.
REQ-036 Reset mid-BUSY abandons the transaction; no done pulse; after release, held requests re-arbitrate from IDLE.

Verification
REQ-037 d_rd LW addr 0x100, mem_ready immediate, mem_rdata 0xDEADBEEF -> mem_addr 0x100, d_done 1 cycle after mem_req, d_rdata 0xDEADBEEF.
REQ-038 SB addr 0x203, d_wdata 0xA5 -> mem_addr 0x200, mem_wstrb 1000, mem_wdata[31:24]=0xA5, mem_we=1.
REQ-039 LB addr 0x2, mem_rdata 0x00800000 -> d_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-040 i_req and data held continuously, ready immediate -> grant order D, D, I, D, D, I.
REQ-041 LW addr 0x102 -> d_done with d_err=1, mem_req never asserted; mem_ready held 0 -> d_err after TIMEOUT cycles.
REQ-042 rst pulled low during BUSY_I -> mem_req 0 asynchronously, i_done never pulses, fetch reissued after release.
